// File: rtl/text_buffer_writer.sv
// text_buffer_writer: 4x16 character buffer with write cursor, control codes and a clear/scroll engine.
// Optional macro TEXT_SCROLL_EN: a row advance past row 3 scrolls the screen up instead of wrapping to row 0.
module text_buffer_writer #(
    parameter logic [6:0] CLEAR_CHAR = 7'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [6:0] wr_char,
    output logic       wr_ready,
    input  logic [1:0] rd_row,
    input  logic [3:0] rd_col,
    output logic [6:0] rd_char,
    output logic [1:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic       busy
);

`ifdef TEXT_SCROLL_EN
    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;
`else
    typedef enum logic [1:0] {IDLE, CLEAR} state_t;
`endif

    state_t     state, state_nxt;
    logic [5:0] idx, idx_nxt;
    logic [5:0] cur, cur_nxt;
    logic       we;
    logic [5:0] waddr;
    logic [6:0] wdata;
    logic       printable;
    logic [6:0] mem [64];

    assign printable  = (wr_char >= 7'h20) && (wr_char <= 7'h7E);
    assign wr_ready   = (state == IDLE);
    assign busy       = !wr_ready;
    assign cursor_row = cur[5:4];
    assign cursor_col = cur[3:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= CLEAR;
            idx     <= 6'd0;
            cur     <= 6'd0;
            rd_char <= 7'h00;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cur     <= cur_nxt;
            rd_char <= mem[{rd_row, rd_col}];
        end
    end

    // Single write port; the read above sees the pre-edge contents on a collision.
    always_ff @(posedge clk) begin
        if (we && reset) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cur_nxt   = cur;
        we        = 1'b0;
        waddr     = idx;
        wdata     = CLEAR_CHAR;
        case (state)
            IDLE: begin
                if (wr_valid) begin
                    if (printable) begin
                        we      = 1'b1;
                        waddr   = cur;
                        wdata   = wr_char;
                        cur_nxt = cur + 6'd1;
                    end else begin
                        case (wr_char)
                            7'h0D: cur_nxt = {cur[5:4], 4'd0};
                            7'h0A: cur_nxt = {cur[5:4] + 2'd1, 4'd0};
                            7'h08: begin
                                if (cur != 6'd0) begin
                                    we      = 1'b1;
                                    waddr   = cur - 6'd1;
                                    cur_nxt = cur - 6'd1;
                                end
                            end
                            7'h0C: begin
                                state_nxt = CLEAR;
                                idx_nxt   = 6'd0;
                                cur_nxt   = 6'd0;
                            end
                            default: ;
                        endcase
                    end
`ifdef TEXT_SCROLL_EN
                    // Leaving row 3 scrolls instead of wrapping; the cursor parks at the start of row 3.
                    if ((cur[5:4] == 2'd3) &&
                        ((printable && (cur[3:0] == 4'hF)) || (wr_char == 7'h0A))) begin
                        state_nxt = SCROLL;
                        idx_nxt   = 6'd0;
                        cur_nxt   = {2'd3, 4'd0};
                    end
`endif
                end
            end
            CLEAR: begin
                we      = 1'b1;
                waddr   = idx;
                idx_nxt = idx + 6'd1;
                if (idx == 6'd63) begin
                    state_nxt = IDLE;
                end
            end
`ifdef TEXT_SCROLL_EN
            SCROLL: begin
                we      = 1'b1;
                waddr   = idx;
                idx_nxt = idx + 6'd1;
                if (idx < 6'd48) begin
                    wdata = mem[idx + 6'd16];
                end
                if (idx == 6'd63) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = CLEAR;
                idx_nxt   = 6'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Scoreboard bench for text_buffer_writer: a behavioural screen model predicts reads and cursor position.
module tb_text_buffer_writer;

    localparam logic [6:0] CLR = 7'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic [6:0] wr_char;
    logic       wr_ready;
    logic [1:0] rd_row;
    logic [3:0] rd_col;
    logic [6:0] rd_char;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;

    text_buffer_writer #(.CLEAR_CHAR(CLR)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_char(wr_char),
        .wr_ready(wr_ready), .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 0: rd_char, 1: cursor {row,col}
        logic [6:0] exp;
        int         tag;
    } item_t;

    item_t q[$];
    logic  req = 1'b0;
    int    total = 0;
    int    bad = 0;

    logic [6:0] m [64];
    int         crow, ccol;

    function automatic void check(string name, int tag, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, tag, act, exp);
        end
    endfunction

    // Screen model: plain arithmetic over a 64-entry array and a (row, col) pair.
    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m[i] = CLR;
        crow = 0;
        ccol = 0;
    endfunction

    function automatic void model_apply(logic [6:0] c);
        bit adv;
        int p;
        adv = 0;
        if (c >= 7'h20 && c <= 7'h7E) begin
            m[crow * 16 + ccol] = c;
            ccol++;
            if (ccol == 16) begin ccol = 0; adv = 1; end
        end else if (c == 7'h0D) begin
            ccol = 0;
        end else if (c == 7'h0A) begin
            ccol = 0;
            adv = 1;
        end else if (c == 7'h08) begin
            p = crow * 16 + ccol;
            if (p > 0) begin
                p = p - 1;
                m[p] = CLR;
                crow = p / 16;
                ccol = p % 16;
            end
        end else if (c == 7'h0C) begin
            model_reset();
        end
        if (adv) begin
            if (crow < 3) begin
                crow++;
            end else begin
`ifdef TEXT_SCROLL_EN
                for (int i = 0; i < 48; i++) m[i] = m[i + 16];
                for (int i = 48; i < 64; i++) m[i] = CLR;
                crow = 3;
`else
                crow = 0;
`endif
            end
        end
    endfunction

    // Monitor: a request sampled at a rising edge is judged just after that edge.
    always @(posedge clk) begin
        item_t it;
        if (req) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: got no expectation, expected one queued");
            end else begin
                it = q.pop_front();
                #1;
                if (it.kind == 0)
                    check("rd_char", it.tag, {25'd0, rd_char}, {25'd0, it.exp});
                else
                    check("cursor", it.tag, {26'd0, cursor_row, cursor_col}, {25'd0, it.exp});
            end
        end
    end

    // All driver tasks start and end on a falling edge.
    task automatic wait_idle(input int tag);
        int w;
        w = 0;
        while (!wr_ready && w < 300) begin @(negedge clk); w++; end
        if (!wr_ready) check("idle_timeout", tag, {31'd0, wr_ready}, 32'd1);
    endtask

    task automatic send(input logic [6:0] c);
        wr_valid = 1'b1;
        wr_char  = c;
        wait_idle(c);
        @(negedge clk);
        wr_valid = 1'b0;
        wr_char  = $urandom_range(0, 127);
        model_apply(c);
    endtask

    task automatic chk_read(input int a);
        {rd_row, rd_col} = a[5:0];
        q.push_back('{kind: 0, exp: m[a], tag: a});
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic chk_cur(input int tag);
        wait_idle(tag);
        q.push_back('{kind: 1, exp: 7'(crow * 16 + ccol), tag: tag});
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic dump();
        wait_idle(999);
        for (int a = 0; a < 64; a++) chk_read(a);
    endtask

    task automatic count_release(input int tag);
        int n;
        n = 0;
        reset = 1'b1;
        do begin @(negedge clk); n++; end while (!wr_ready && n < 200);
        check("ready_after_reset", tag, n, 64);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, r;
        logic [6:0] old, c;
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_char  = 7'h00;
        rd_row   = 2'd0;
        rd_col   = 4'd0;
        model_reset();

        // Power-on reset and the mandatory initial clear
        repeat (3) @(negedge clk);
        check("rst_rd_char", 0, {25'd0, rd_char}, 32'd0);
        check("rst_ready", 0, {31'd0, wr_ready}, 32'd0);
        check("rst_busy", 0, {31'd0, busy}, 32'd1);
        check("rst_cursor", 0, {26'd0, cursor_row, cursor_col}, 32'd0);
        count_release(1);
        dump();
        chk_cur(2);

        // "HI" back to back, then latency and same-cell collision
        send(7'h48);
        chk_read(0);
        send(7'h49);
        chk_read(1);
        chk_cur(3);
        a   = crow * 16 + ccol;
        old = m[a];
        wr_valid = 1'b1;
        wr_char  = 7'h51;
        {rd_row, rd_col} = a[5:0];
        q.push_back('{kind: 0, exp: old, tag: 100});
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wr_valid = 1'b0;
        model_apply(7'h51);
        chk_read(a);

        // Backspace across a row boundary and at the home position
        send(7'h0C);
        for (int i = 0; i < 16; i++) send(7'h41);
        chk_cur(4);
        send(7'h08);
        chk_cur(5);
        chk_read(15);
        chk_read(14);
        send(7'h0C);
        send(7'h08);
        chk_cur(6);
        dump();

        // Row advance out of row 3 from a printable character at column 15
        for (int i = 0; i < 16; i++) send(7'h30 + 7'(i));
        send(7'h0A);
        send(7'h0A);
        send(7'h0A);
        for (int i = 0; i < 15; i++) send(7'h61 + 7'(i));
        chk_cur(7);
        send(7'h5A);
        n = 0;
        while (!wr_ready && n < 200) begin n++; @(negedge clk); end
`ifdef TEXT_SCROLL_EN
        check("scroll_busy_cycles", 8, n, 64);
`else
        check("scroll_busy_cycles", 8, n, 0);
`endif
        chk_cur(9);
        dump();

        // Reset in the middle of a clear restarts it from the beginning
        send(7'h0C);
        repeat (30) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midclear_ready", 10, {31'd0, wr_ready}, 32'd0);
        check("midclear_cursor", 10, {26'd0, cursor_row, cursor_col}, 32'd0);
        model_reset();
        count_release(11);
        dump();

        // A non-printable code held while busy is consumed without effect
        send(7'h4B);
        send(7'h0C);
        send(7'h07);
        chk_cur(12);
        dump();

        // Randomized character stream against the model
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      c = 7'($urandom_range(32, 126));
            else if (r < 70) c = 7'h0A;
            else if (r < 78) c = 7'h0D;
            else if (r < 88) c = 7'h08;
            else if (r < 90) c = 7'h0C;
            else if (r < 95) c = 7'h7F;
            else             c = 7'($urandom_range(14, 31));
            send(c);
            chk_cur(1000 + k);
            if (k % 40 == 39) dump();
        end
        dump();

        repeat (3) @(negedge clk);
        check("scoreboard_leftover", 0, q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
